// File: rtl/openram_port_arbiter.sv
// Round-robin arbiter sharing port 0 of the 1 kB OpenRAM macro between requesters A and B.
// Optional grant/stall statistics counters are enabled by defining OPENRAM_ARB_STATS_EN.
module openram_port_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 32,
  parameter int MW       = 4,
  parameter int READ_LAT = 1
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [MW-1:0] a_wmask,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [MW-1:0] b_wmask,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
`ifdef OPENRAM_ARB_STATS_EN
  input  logic          stats_clr,
  output logic [15:0]   gnt_cnt_a,
  output logic [15:0]   gnt_cnt_b,
  output logic [15:0]   stall_cnt,
`endif
  output logic          openram_clk0,
  output logic          openram_csb0,
  output logic          openram_web0,
  output logic [MW-1:0] openram_wmask0,
  output logic [AW-1:0] openram_addr0,
  output logic [DW-1:0] openram_din0,
  input  logic [DW-1:0] openram_dout0
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

  localparam logic [1:0] LAT = READ_LAT[1:0];

  state_t        r_state, w_state_nxt;
  logic          r_last_b, w_last_b_nxt;
  logic          r_sel_b, w_sel_b_nxt;
  logic [1:0]    r_cnt, w_cnt_nxt;
  logic          r_csb, w_csb_nxt;
  logic          r_web, w_web_nxt;
  logic [MW-1:0] r_wmask, w_wmask_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic [DW-1:0] r_din, w_din_nxt;
  logic          r_gnt_a, w_gnt_a_nxt, r_gnt_b, w_gnt_b_nxt;
  logic          r_rvalid_a, w_rvalid_a_nxt, r_rvalid_b, w_rvalid_b_nxt;
  logic [DW-1:0] r_rdata_a, w_rdata_a_nxt, r_rdata_b, w_rdata_b_nxt;

  logic          w_win_b;
  logic          w_win_we;
  logic [MW-1:0] w_win_wmask;
  logic [AW-1:0] w_win_addr;
  logic [DW-1:0] w_win_wdata;

  // On a tie the side that was not granted last wins.
  assign w_win_b     = b_req & (~a_req | ~r_last_b);
  assign w_win_we    = w_win_b ? b_we    : a_we;
  assign w_win_wmask = w_win_b ? b_wmask : a_wmask;
  assign w_win_addr  = w_win_b ? b_addr  : a_addr;
  assign w_win_wdata = w_win_b ? b_wdata : a_wdata;

  // Next-state and next-output logic of the arbitration FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_last_b_nxt   = r_last_b;
    w_sel_b_nxt    = r_sel_b;
    w_cnt_nxt      = r_cnt;
    w_csb_nxt      = r_csb;
    w_web_nxt      = r_web;
    w_wmask_nxt    = r_wmask;
    w_addr_nxt     = r_addr;
    w_din_nxt      = r_din;
    w_gnt_a_nxt    = 1'b0;
    w_gnt_b_nxt    = 1'b0;
    w_rvalid_a_nxt = 1'b0;
    w_rvalid_b_nxt = 1'b0;
    w_rdata_a_nxt  = r_rdata_a;
    w_rdata_b_nxt  = r_rdata_b;
    case (r_state)
      IDLE: begin
        if (a_req | b_req) begin
          w_state_nxt  = ISSUE;
          w_last_b_nxt = w_win_b;
          w_sel_b_nxt  = w_win_b;
          w_csb_nxt    = 1'b0;
          w_web_nxt    = ~w_win_we;
          w_wmask_nxt  = w_win_we ? w_win_wmask : {MW{1'b0}};
          w_addr_nxt   = w_win_addr;
          w_din_nxt    = w_win_wdata;
          w_gnt_a_nxt  = ~w_win_b;
          w_gnt_b_nxt  = w_win_b;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE: begin
        w_csb_nxt   = 1'b1;
        w_web_nxt   = 1'b1;
        w_wmask_nxt = {MW{1'b0}};
        if (!r_web) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = WAIT;
          w_cnt_nxt   = LAT;
        end
      end
      WAIT: begin
        if (r_cnt == 2'd1) begin
          w_state_nxt = IDLE;
          if (r_sel_b) begin
            w_rdata_b_nxt  = openram_dout0;
            w_rvalid_b_nxt = 1'b1;
          end else begin
            w_rdata_a_nxt  = openram_dout0;
            w_rvalid_a_nxt = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and registered SRAM/requester outputs; reset leaves B as last grant.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_state    <= IDLE;
      r_last_b   <= 1'b1;
      r_sel_b    <= 1'b0;
      r_cnt      <= 2'd0;
      r_csb      <= 1'b1;
      r_web      <= 1'b1;
      r_wmask    <= {MW{1'b0}};
      r_addr     <= {AW{1'b0}};
      r_din      <= {DW{1'b0}};
      r_gnt_a    <= 1'b0;
      r_gnt_b    <= 1'b0;
      r_rvalid_a <= 1'b0;
      r_rvalid_b <= 1'b0;
      r_rdata_a  <= {DW{1'b0}};
      r_rdata_b  <= {DW{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_last_b   <= w_last_b_nxt;
      r_sel_b    <= w_sel_b_nxt;
      r_cnt      <= w_cnt_nxt;
      r_csb      <= w_csb_nxt;
      r_web      <= w_web_nxt;
      r_wmask    <= w_wmask_nxt;
      r_addr     <= w_addr_nxt;
      r_din      <= w_din_nxt;
      r_gnt_a    <= w_gnt_a_nxt;
      r_gnt_b    <= w_gnt_b_nxt;
      r_rvalid_a <= w_rvalid_a_nxt;
      r_rvalid_b <= w_rvalid_b_nxt;
      r_rdata_a  <= w_rdata_a_nxt;
      r_rdata_b  <= w_rdata_b_nxt;
    end
  end

  assign openram_clk0   = wb_clk_i;
  assign openram_csb0   = r_csb;
  assign openram_web0   = r_web;
  assign openram_wmask0 = r_wmask;
  assign openram_addr0  = r_addr;
  assign openram_din0   = r_din;
  assign a_gnt          = r_gnt_a;
  assign b_gnt          = r_gnt_b;
  assign a_rvalid       = r_rvalid_a;
  assign b_rvalid       = r_rvalid_b;
  assign a_rdata        = r_rdata_a;
  assign b_rdata        = r_rdata_b;

`ifdef OPENRAM_ARB_STATS_EN
  logic [15:0] r_gnt_cnt_a, r_gnt_cnt_b, r_stall_cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  // Saturating statistics; clear has priority over any increment.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_gnt_cnt_a <= 16'd0;
      r_gnt_cnt_b <= 16'd0;
      r_stall_cnt <= 16'd0;
    end else if (stats_clr) begin
      r_gnt_cnt_a <= 16'd0;
      r_gnt_cnt_b <= 16'd0;
      r_stall_cnt <= 16'd0;
    end else begin
      r_gnt_cnt_a <= sat_inc(r_gnt_cnt_a, r_gnt_a);
      r_gnt_cnt_b <= sat_inc(r_gnt_cnt_b, r_gnt_b);
      r_stall_cnt <= sat_inc(r_stall_cnt, (a_req | b_req) & ~(r_gnt_a | r_gnt_b));
    end
  end

  assign gnt_cnt_a = r_gnt_cnt_a;
  assign gnt_cnt_b = r_gnt_cnt_b;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_openram_port_arbiter.sv
// Directed self-checking bench for openram_port_arbiter with a behavioural 1-cycle SRAM model.
module tb_openram_port_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [3:0]  a_wmask = 4'h0, b_wmask = 4'h0;
  logic [7:0]  a_addr = 8'h0, b_addr = 8'h0;
  logic [31:0] a_wdata = 32'h0, b_wdata = 32'h0;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic        ram_clk, csb0, web0;
  logic [3:0]  wmask0;
  logic [7:0]  addr0;
  logic [31:0] din0, dout0;
  logic [31:0] mem [0:255];
`ifdef OPENRAM_ARB_STATS_EN
  logic        stats_clr = 1'b0;
  logic [15:0] gnt_cnt_a, gnt_cnt_b, stall_cnt;
`endif
  int n_checks = 0;
  int n_fail   = 0;

  openram_port_arbiter dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .a_req(a_req), .a_we(a_we), .a_wmask(a_wmask), .a_addr(a_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_wmask(b_wmask), .b_addr(b_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
`ifdef OPENRAM_ARB_STATS_EN
    .stats_clr(stats_clr), .gnt_cnt_a(gnt_cnt_a), .gnt_cnt_b(gnt_cnt_b), .stall_cnt(stall_cnt),
`endif
    .openram_clk0(ram_clk), .openram_csb0(csb0), .openram_web0(web0),
    .openram_wmask0(wmask0), .openram_addr0(addr0), .openram_din0(din0),
    .openram_dout0(dout0)
  );

  always #5 clk = ~clk;

  // SRAM model: command sampled on the rising edge, read data valid one edge later.
  always @(posedge clk) begin
    if (!csb0) begin
      if (!web0) begin
        for (int i = 0; i < 4; i++)
          if (wmask0[i]) mem[addr0][i*8 +: 8] <= din0[i*8 +: 8];
      end else begin
        dout0 <= mem[addr0];
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Raise a request at the current negedge and count negedges until its grant (-1 if none).
  task automatic drive_req(input logic side_b, input logic we, input logic [7:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wmask, output int lat);
    lat = -1;
    if (side_b) begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; b_wmask = wmask;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; a_wmask = wmask;
    end
    for (int i = 1; i <= 8 && lat < 0; i++) begin
      @(negedge clk);
      if ((side_b ? b_gnt : a_gnt) === 1'b1) lat = i;
    end
    if (side_b) b_req = 1'b0;
    else a_req = 1'b0;
  endtask

  task automatic wait_rvalid(input logic side_b, output int lat);
    lat = -1;
    for (int i = 1; i <= 8 && lat < 0; i++) begin
      @(negedge clk);
      if ((side_b ? b_rvalid : a_rvalid) === 1'b1) lat = i;
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (csb0 !== 1'b1) begin n_fail++; $display("FAIL rst_csb0: got %b exp 1", csb0); end
    n_checks++; if (web0 !== 1'b1) begin n_fail++; $display("FAIL rst_web0: got %b exp 1", web0); end
    n_checks++; if (wmask0 !== 4'h0) begin n_fail++; $display("FAIL rst_wmask0: got %h exp 0", wmask0); end
    n_checks++; if (addr0 !== 8'h0) begin n_fail++; $display("FAIL rst_addr0: got %h exp 0", addr0); end
    n_checks++; if (din0 !== 32'h0) begin n_fail++; $display("FAIL rst_din0: got %h exp 0", din0); end
    n_checks++; if ({a_gnt, b_gnt, a_rvalid, b_rvalid} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_gnt_rvalid: got %b exp 0000", {a_gnt, b_gnt, a_rvalid, b_rvalid}); end
    n_checks++; if ({a_rdata, b_rdata} !== 64'h0) begin
      n_fail++; $display("FAIL rst_rdata: got %h exp 0", {a_rdata, b_rdata}); end
`ifdef OPENRAM_ARB_STATS_EN
    n_checks++; if ({gnt_cnt_a, gnt_cnt_b, stall_cnt} !== 48'h0) begin
      n_fail++; $display("FAIL rst_stats: got %h exp 0", {gnt_cnt_a, gnt_cnt_b, stall_cnt}); end
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_write;
    int lat;
    drive_req(1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL wr_gnt_lat: got %0d exp 1", lat); end
    n_checks++; if ({csb0, web0} !== 2'b00) begin n_fail++; $display("FAIL wr_csb_web: got %b exp 00", {csb0, web0}); end
    n_checks++; if (addr0 !== 8'h10) begin n_fail++; $display("FAIL wr_addr0: got %h exp 10", addr0); end
    n_checks++; if (din0 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_din0: got %h exp deadbeef", din0); end
    n_checks++; if (wmask0 !== 4'hF) begin n_fail++; $display("FAIL wr_wmask0: got %h exp f", wmask0); end
    n_checks++; if (b_gnt !== 1'b0) begin n_fail++; $display("FAIL wr_b_gnt: got %b exp 0", b_gnt); end
    @(negedge clk);
    n_checks++; if ({a_gnt, csb0} !== 2'b01) begin n_fail++; $display("FAIL wr_after: got %b exp 01", {a_gnt, csb0}); end
  endtask

  task automatic test_readback;
    int lat;
    drive_req(1'b0, 1'b0, 8'h10, 32'h0, 4'hA, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL rd_gnt_lat: got %0d exp 1", lat); end
    n_checks++; if ({csb0, web0, wmask0} !== 6'b010000) begin
      n_fail++; $display("FAIL rd_cmd: got %b exp 010000", {csb0, web0, wmask0}); end
    wait_rvalid(1'b0, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL rd_rvalid_lat: got %0d exp 2", lat); end
    n_checks++; if (a_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h exp deadbeef", a_rdata); end
    n_checks++; if (b_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_b_rvalid: got %b exp 0", b_rvalid); end
    @(negedge clk);
    n_checks++; if ({a_rvalid, a_rdata} !== {1'b0, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL rd_hold: got %b/%h exp 0/deadbeef", a_rvalid, a_rdata); end
  endtask

  task automatic test_tie;
    int ngnt = 0, na_rv = 0, nb_rv = 0;
    logic prev_gnt = 1'b0;
    mem[8'h20] = 32'hCAFEF00D;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h10;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h20;
    for (int cyc = 0; cyc < 60 && ngnt < 8; cyc++) begin
      @(negedge clk);
      n_checks++; if (a_gnt && b_gnt) begin n_fail++; $display("FAIL tie_both_gnt: cycle %0d", cyc); end
      n_checks++; if ((a_gnt || b_gnt) && prev_gnt) begin n_fail++; $display("FAIL tie_back_to_back_gnt: cycle %0d", cyc); end
      if (a_gnt || b_gnt) begin
        n_checks++; if (b_gnt !== ngnt[0]) begin
          n_fail++; $display("FAIL tie_order: grant %0d got b_gnt=%b exp %b", ngnt, b_gnt, ngnt[0]); end
        ngnt++;
      end
      if (a_rvalid) begin na_rv++; n_checks++; if (a_rdata !== 32'hDEADBEEF) begin
        n_fail++; $display("FAIL tie_a_rdata: got %h exp deadbeef", a_rdata); end end
      if (b_rvalid) begin nb_rv++; n_checks++; if (b_rdata !== 32'hCAFEF00D) begin
        n_fail++; $display("FAIL tie_b_rdata: got %h exp cafef00d", b_rdata); end end
      prev_gnt = a_gnt | b_gnt;
    end
    a_req = 1'b0; b_req = 1'b0;
    n_checks++; if (ngnt !== 8) begin n_fail++; $display("FAIL tie_grants: got %0d exp 8", ngnt); end
    repeat (4) begin
      @(negedge clk);
      if (a_rvalid) na_rv++;
      if (b_rvalid) nb_rv++;
    end
    n_checks++; if ({na_rv, nb_rv} !== {32'd4, 32'd4}) begin
      n_fail++; $display("FAIL tie_rvalids: got a=%0d b=%0d exp 4/4", na_rv, nb_rv); end
  endtask

  task automatic test_byte_mask;
    int lat;
    drive_req(1'b1, 1'b1, 8'h30, 32'h11223344, 4'hF, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL bm_wr1_lat: got %0d exp 1", lat); end
    @(negedge clk);
    drive_req(1'b1, 1'b1, 8'h30, 32'hAABBCCDD, 4'b0101, lat);
    n_checks++; if (wmask0 !== 4'b0101) begin n_fail++; $display("FAIL bm_wmask0: got %b exp 0101", wmask0); end
    @(negedge clk);
    drive_req(1'b1, 1'b0, 8'h30, 32'h0, 4'hF, lat);
    wait_rvalid(1'b1, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL bm_rvalid_lat: got %0d exp 2", lat); end
    n_checks++; if (b_rdata !== 32'h11BB33DD) begin n_fail++; $display("FAIL bm_rdata: got %h exp 11bb33dd", b_rdata); end
    n_checks++; if (a_rvalid !== 1'b0) begin n_fail++; $display("FAIL bm_a_rvalid: got %b exp 0", a_rvalid); end
  endtask

  task automatic test_back_to_back;
    int lat;
    drive_req(1'b0, 1'b1, 8'h40, 32'h01020304, 4'hF, lat);
    drive_req(1'b1, 1'b1, 8'h41, 32'h0A0B0C0D, 4'hF, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL b2b_next_gnt: got %0d exp 2", lat); end
    @(negedge clk);
    drive_req(1'b0, 1'b0, 8'h40, 32'h0, 4'h0, lat);
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'h42;
    @(negedge clk);
    b_req = 1'b0;
    n_checks++; if ({a_rvalid, a_rdata} !== {1'b1, 32'h01020304}) begin
      n_fail++; $display("FAIL b2b_rdata: got %b/%h exp 1/01020304", a_rvalid, a_rdata); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if ({a_gnt, b_gnt, csb0} !== 3'b001) begin
        n_fail++; $display("FAIL dropped_req: cycle %0d got %b exp 001", i, {a_gnt, b_gnt, csb0}); end
    end
  endtask

  task automatic test_reset_wait;
    int lat;
    drive_req(1'b0, 1'b0, 8'h10, 32'h0, 4'h0, lat);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++; if ({csb0, a_gnt, a_rvalid} !== 3'b100) begin
      n_fail++; $display("FAIL rw_outputs: got %b exp 100", {csb0, a_gnt, a_rvalid}); end
    n_checks++; if (a_rdata !== 32'h0) begin n_fail++; $display("FAIL rw_rdata_clr: got %h exp 0", a_rdata); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      n_checks++; if (a_rvalid !== 1'b0) begin n_fail++; $display("FAIL rw_no_rvalid: cycle %0d got 1 exp 0", i); end
    end
    drive_req(1'b0, 1'b0, 8'h10, 32'h0, 4'h0, lat);
    n_checks++; if ({lat == 1, csb0} !== 2'b10) begin
      n_fail++; $display("FAIL rw_regrant: got lat=%0d csb0=%b exp 1/0", lat, csb0); end
    wait_rvalid(1'b0, lat);
    n_checks++; if (a_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rw_readback: got %h exp deadbeef", a_rdata); end
  endtask

`ifdef OPENRAM_ARB_STATS_EN
  task automatic test_stats;
    int lat;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_req(i >= 3, 1'b1, 8'h50, 32'h0, 4'h0, lat);
      @(negedge clk);
    end
    // each isolated grant is preceded by exactly one IDLE cycle with the request pending
    n_checks++; if ({gnt_cnt_a, gnt_cnt_b, stall_cnt} !== {16'd3, 16'd2, 16'd5}) begin
      n_fail++; $display("FAIL stats_counts: got %0d/%0d/%0d exp 3/2/5", gnt_cnt_a, gnt_cnt_b, stall_cnt); end
    stats_clr = 1'b1;
    a_req = 1'b1; a_we = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0; a_req = 1'b0;
    n_checks++; if ({gnt_cnt_a, gnt_cnt_b, stall_cnt} !== 48'h0) begin
      n_fail++; $display("FAIL stats_clr: got %0d/%0d/%0d exp 0/0/0", gnt_cnt_a, gnt_cnt_b, stall_cnt); end
    repeat (2) @(negedge clk);
    force dut.r_stall_cnt = 16'hFFFF;
    #1 release dut.r_stall_cnt;
    a_req = 1'b1;
    @(negedge clk);
    a_req = 1'b0;
    n_checks++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL stats_sat: got %h exp ffff", stall_cnt); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset;
    test_single_write;
    test_readback;
    test_tie;
    test_byte_mask;
    test_back_to_back;
    test_reset_wait;
`ifdef OPENRAM_ARB_STATS_EN
    test_stats;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
